win_banner_ctrl: RTL and testbench

- Sequences the end-of-game "win" sprite overlay.
- On a win event it slides the 256x256 win sprite vertically from the top edge to screen centre, one step per video frame.
- It then blinks the sprite for a fixed number of frames and finally holds it steady until the game is cleared.
- It drives the sprite position and enable inputs of the win sprite display stage and sits between game logic and the VGA pixel mux.

---
 rtl/win_banner_ctrl.sv | 108 ++++++++++
 tb/tb_win_banner_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/win_banner_ctrl.sv
// Win banner sequencer: slides the win sprite from the top edge to screen centre,
// blinks it for a fixed number of frames, then holds it until the game is cleared.
module win_banner_ctrl #(
    parameter int SCREEN_W      = 640,
    parameter int SCREEN_H      = 480,
    parameter int SPRITE_SIZE   = 256,
    parameter int SLIDE_STEP    = 4,
    parameter int BLINK_PERIOD  = 8,
    parameter int BLINK_TOGGLES = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        win_event,
    input  logic        clear,
    input  logic        frame_tick,
    output logic [10:0] win_x,
    output logic [9:0]  win_y,
    output logic        win_visible,
    output logic        busy,
    output logic        done
);

    localparam logic [10:0] X_CTR = 11'((SCREEN_W - SPRITE_SIZE) / 2);
    localparam logic [10:0] Y_TGT = 11'((SCREEN_H - SPRITE_SIZE) / 2);
    localparam logic [10:0] STEP  = 11'(SLIDE_STEP);

    localparam int FW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
    localparam int TW = $clog2(BLINK_TOGGLES + 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_PERIOD - 1);
    localparam logic [TW-1:0] TOGGLE_END = TW'(BLINK_TOGGLES);

    typedef enum logic [1:0] {IDLE, SLIDE, BLINK, SHOW} state_t;

    state_t          state;
    logic [FW-1:0]   frame_cnt;
    logic [TW-1:0]   toggle_cnt;
    logic [10:0]     slide_sum;
    logic [TW-1:0]   toggle_next;

    // Sum is one bit wider than win_y so the clamp test sees any overshoot.
    assign slide_sum   = {1'b0, win_y} + STEP;
    assign toggle_next = toggle_cnt + TW'(1);
    assign win_x       = X_CTR;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state       <= IDLE;
            win_y       <= '0;
            win_visible <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            frame_cnt   <= '0;
            toggle_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_event) begin
                        state       <= SLIDE;
                        win_y       <= '0;
                        win_visible <= 1'b1;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                    end
                end
                SLIDE: begin
                    if (frame_tick) begin
                        if (slide_sum >= Y_TGT) begin
                            state       <= BLINK;
                            win_y       <= Y_TGT[9:0];
                            win_visible <= 1'b1;
                            frame_cnt   <= '0;
                            toggle_cnt  <= '0;
                        end else begin
                            win_y <= slide_sum[9:0];
                        end
                    end
                end
                BLINK: begin
                    if (frame_tick) begin
                        if (frame_cnt == FRAME_LAST) begin
                            frame_cnt <= '0;
                            // The final toggle is replaced by the steady SHOW state.
                            if (toggle_next == TOGGLE_END) begin
                                state       <= SHOW;
                                win_visible <= 1'b1;
                                busy        <= 1'b0;
                                done        <= 1'b1;
                                toggle_cnt  <= '0;
                            end else begin
                                win_visible <= ~win_visible;
                                toggle_cnt  <= toggle_next;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + FW'(1);
                        end
                    end
                end
                SHOW: begin
                    win_y       <= Y_TGT[9:0];
                    win_visible <= 1'b1;
                    done        <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_win_banner_ctrl.sv
// Scoreboard bench for win_banner_ctrl: stimulus pushes hand-computed expectations,
// a monitor pops one per cycle and compares against the selected DUT instance.
module tb_win_banner_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        win_event = 1'b0;
    logic        clear = 1'b0;
    logic        frame_tick = 1'b0;

    logic [10:0] x4, x5;
    logic [9:0]  y4, y5;
    logic        vis4, vis5, busy4, busy5, done4, done5;

    typedef struct {
        logic       sel;
        logic [9:0] y;
        logic       vis;
        logic       busy;
        logic       done;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    win_banner_ctrl dut (
        .clk(clk), .reset(reset), .win_event(win_event), .clear(clear),
        .frame_tick(frame_tick), .win_x(x4), .win_y(y4),
        .win_visible(vis4), .busy(busy4), .done(done4)
    );

    win_banner_ctrl #(.SLIDE_STEP(5)) dut5 (
        .clk(clk), .reset(reset), .win_event(win_event), .clear(clear),
        .frame_tick(frame_tick), .win_x(x5), .win_y(y5),
        .win_visible(vis5), .busy(busy5), .done(done5)
    );

    task automatic cmp(input string nm, input string field, input logic [31:0] act,
                       input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s.%s: got %0d, expected %0d", nm, field, act, req);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        logic [10:0] ax;
        logic [9:0]  ay;
        logic        av, ab, ad;
        ax = e.sel ? x5 : x4;
        ay = e.sel ? y5 : y4;
        av = e.sel ? vis5 : vis4;
        ab = e.sel ? busy5 : busy4;
        ad = e.sel ? done5 : done4;
        cmp(e.name, "win_x", 32'(ax), 32'd192);
        cmp(e.name, "win_y", 32'(ay), 32'(e.y));
        cmp(e.name, "win_visible", 32'(av), 32'(e.vis));
        cmp(e.name, "busy", 32'(ab), 32'(e.busy));
        cmp(e.name, "done", 32'(ad), 32'(e.done));
    endtask

    task automatic applyStimulus(input logic rst, input logic we, input logic clr,
                                 input logic ft, input logic sel, input logic [9:0] ey,
                                 input logic ev, input logic eb, input logic ed,
                                 input string nm);
        exp_t e;
        @(negedge clk);
        reset      = rst;
        win_event  = we;
        clear      = clr;
        frame_tick = ft;
        e.sel  = sel;
        e.y    = ey;
        e.vis  = ev;
        e.busy = eb;
        e.done = ed;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    // Defaults: toggle after every 8th blink tick, SHOW after tick 48.
    function automatic logic blink_vis(input int t);
        if (t >= 48) return 1'b1;
        return ((t / 8) % 2) == 0;
    endfunction

    always begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(1, 0, 0, 0, 0, 10'd0, 0, 0, 0, "reset0");
        applyStimulus(1, 0, 0, 0, 0, 10'd0, 0, 0, 0, "reset1");
        for (int i = 0; i < 5; i++)
            applyStimulus(0, 0, 0, 1, 0, 10'd0, 0, 0, 0, "idle_tick");

        // Slide at step 4 with an ignored second win_event mid-slide.
        applyStimulus(0, 1, 0, 0, 0, 10'd0, 1, 1, 0, "win_start");
        for (int k = 1; k <= 28; k++) begin
            applyStimulus(0, (k == 10), 0, 0, 0, 10'(4 * (k - 1)), 1, 1, 0, "slide_hold");
            applyStimulus(0, 0, 0, 1, 0, 10'(4 * k), 1, 1, 0, "slide_tick");
        end

        for (int t = 1; t <= 48; t++) begin
            applyStimulus(0, (t == 20), 0, 0, 0, 10'd112, blink_vis(t - 1), 1, 0, "blink_hold");
            applyStimulus(0, 0, 0, 1, 0, 10'd112, blink_vis(t), (t < 48), (t >= 48), "blink_tick");
        end

        applyStimulus(0, 0, 0, 1, 0, 10'd112, 1, 0, 1, "show_tick");
        applyStimulus(0, 1, 0, 1, 0, 10'd112, 1, 0, 1, "show_win_ignored");
        applyStimulus(0, 0, 1, 0, 0, 10'd0, 0, 0, 0, "show_clear");

        // Clear in BLINK while the sprite is hidden; clear beats frame_tick.
        applyStimulus(0, 1, 0, 0, 0, 10'd0, 1, 1, 0, "win2_start");
        for (int k = 1; k <= 28; k++)
            applyStimulus(0, 0, 0, 1, 0, 10'(4 * k), 1, 1, 0, "slide2_tick");
        for (int t = 1; t <= 8; t++)
            applyStimulus(0, 0, 0, 1, 0, 10'd112, blink_vis(t), 1, 0, "blink2_tick");
        applyStimulus(0, 0, 1, 1, 0, 10'd0, 0, 0, 0, "blink_clear");
        applyStimulus(0, 0, 0, 1, 0, 10'd0, 0, 0, 0, "after_clear_tick");

        applyStimulus(0, 1, 1, 0, 0, 10'd0, 0, 0, 0, "clear_beats_win");
        applyStimulus(0, 1, 0, 1, 0, 10'd0, 1, 1, 0, "win_with_tick");
        applyStimulus(0, 0, 0, 1, 0, 10'd4, 1, 1, 0, "first_step");
        applyStimulus(0, 0, 0, 0, 0, 10'd4, 1, 1, 0, "step_hold");
        applyStimulus(1, 0, 0, 1, 0, 10'd0, 0, 0, 0, "reset_mid");

        // Step 5 instance: 0,5,...,110 then clamp to 112.
        applyStimulus(1, 0, 0, 0, 1, 10'd0, 0, 0, 0, "s5_reset");
        applyStimulus(0, 1, 0, 0, 1, 10'd0, 1, 1, 0, "s5_start");
        for (int k = 1; k <= 22; k++)
            applyStimulus(0, 0, 0, 1, 1, 10'(5 * k), 1, 1, 0, "s5_tick");
        applyStimulus(0, 0, 0, 1, 1, 10'd112, 1, 1, 0, "s5_clamp");
        applyStimulus(0, 0, 0, 0, 1, 10'd112, 1, 1, 0, "s5_hold");
        applyStimulus(0, 0, 0, 1, 1, 10'd112, 1, 1, 0, "s5_blink_tick");

        @(negedge clk);
        reset      = 1'b0;
        win_event  = 1'b0;
        clear      = 1'b0;
        frame_tick = 1'b0;

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
